// File: rtl/health_tracker.sv
// Player/NPC hit-point tracker: one damage step per frame tick with per-character cooldown,
// registered death flags for stage_control and health-bar pixel flags for color_mapper.
module health_tracker #(
  parameter logic [7:0] MAX_HP          = 8'd100,
  parameter logic [7:0] DAMAGE          = 8'd10,
  parameter logic [5:0] COOLDOWN_FRAMES = 6'd30,
  parameter logic [9:0] BAR_Y           = 10'd20,
  parameter logic [9:0] BAR_H           = 10'd8,
  parameter logic [9:0] P_BAR_X         = 10'd20,
  parameter logic [9:0] N_BAR_X         = 10'd619
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       battle_l,
  input  logic       player_hit,
  input  logic       npc_hit,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [7:0] Player_HP,
  output logic [7:0] NPC_HP,
  output logic       Player_Dead,
  output logic       NPC_Dead,
  output logic       is_player_bar,
  output logic       is_npc_bar
);

  typedef enum logic [1:0] {StAlive, StCooldown, StDead} state_e;

  // Character index 0 is the player, 1 is the NPC.
  localparam int NumChar = 2;

  logic                    frame_clk_q;
  logic                    tick;
  logic [NumChar-1:0]      hit_ok;
  state_e                  state_q [NumChar];
  state_e                  state_d [NumChar];
  logic [NumChar-1:0][7:0] hp_q, hp_d;
  logic [NumChar-1:0][5:0] cnt_q, cnt_d;
  logic [NumChar-1:0]      pend_q, pend_d;
  logic [NumChar-1:0]      dead_q, dead_d;

  assign tick   = frame_clk & ~frame_clk_q;
  assign hit_ok = {npc_hit, player_hit} & {NumChar{battle_l}};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_q <= 1'b0;
      for (int i = 0; i < NumChar; i++) begin
        state_q[i] <= StAlive;
        hp_q[i]    <= MAX_HP;
        cnt_q[i]   <= 6'd0;
        pend_q[i]  <= 1'b0;
        dead_q[i]  <= 1'b0;
      end
    end else begin
      frame_clk_q <= frame_clk;
      state_q     <= state_d;
      hp_q        <= hp_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      dead_q      <= dead_d;
    end
  end

  always_comb begin
    logic [7:0] new_hp;
    new_hp = 8'd0;
    for (int i = 0; i < NumChar; i++) begin
      state_d[i] = state_q[i];
      hp_d[i]    = hp_q[i];
      cnt_d[i]   = cnt_q[i];
      dead_d[i]  = dead_q[i];
      // A contact level lasting many clocks collapses into one hit for the frame.
      pend_d[i]  = battle_l & ~tick & (pend_q[i] | hit_ok[i]);

      if (tick) begin
        unique case (state_q[i])
          StAlive: begin
            if (pend_q[i] || hit_ok[i]) begin
              new_hp  = (hp_q[i] > DAMAGE) ? hp_q[i] - DAMAGE : 8'd0;
              hp_d[i] = new_hp;
              if (new_hp == 8'd0) begin
                state_d[i] = StDead;
                dead_d[i]  = 1'b1;
                cnt_d[i]   = 6'd0;
              end else begin
                state_d[i] = StCooldown;
                cnt_d[i]   = COOLDOWN_FRAMES;
              end
            end
          end
          StCooldown: begin
            if (cnt_q[i] == 6'd1) begin
              state_d[i] = StAlive;
              cnt_d[i]   = 6'd0;
            end else begin
              cnt_d[i] = cnt_q[i] - 6'd1;
            end
          end
          StDead: begin
            hp_d[i]   = 8'd0;
            dead_d[i] = 1'b1;
          end
          default: begin
            state_d[i] = StAlive;
          end
        endcase
      end
    end
  end

  assign Player_HP   = hp_q[0];
  assign NPC_HP      = hp_q[1];
  assign Player_Dead = dead_q[0];
  assign NPC_Dead    = dead_q[1];

  // 11-bit arithmetic so neither bar edge can wrap.
  logic bar_rows;
  assign bar_rows = ({1'b0, DrawY} >= {1'b0, BAR_Y}) &&
                    ({1'b0, DrawY} <  {1'b0, BAR_Y} + {1'b0, BAR_H});

  assign is_player_bar = bar_rows &&
                         ({1'b0, DrawX} >= {1'b0, P_BAR_X}) &&
                         ({1'b0, DrawX} <  {1'b0, P_BAR_X} + {3'b000, hp_q[0]});

  assign is_npc_bar = bar_rows &&
                      ({1'b0, DrawX} <= {1'b0, N_BAR_X}) &&
                      ({1'b0, DrawX} + {3'b000, hp_q[1]} > {1'b0, N_BAR_X});

endmodule

// File: doc/health_tracker.md
Name: health_tracker

Overview:
Tracks player and NPC hit points from per-pixel hitbox contact levels and drives Player_Dead / NPC_Dead into stage_control, replacing the temporary switch inputs.
Applies damage once per frame, with a per-character invulnerability cooldown measured in frames.
Also generates health-bar pixel flags for color_mapper.
Sits between the hitbox instances (upstream) and stage_control / color_mapper (downstream).

Parameters:
MAX_HP, 8'd100, starting and reset HP of each character
DAMAGE, 8'd10, HP removed per accepted hit
COOLDOWN_FRAMES, 6'd30, frames of invulnerability after an accepted non-lethal hit (must be >=1)
BAR_Y, 10'd20, top row of both health bars
BAR_H, 10'd8, bar height in pixels
P_BAR_X, 10'd20, left edge of player bar; bar grows right, 1 px per HP
N_BAR_X, 10'd619, right edge of NPC bar; bar grows left, 1 px per HP

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous active-high reset; top level drives Reset_h || Soft_Reset_h
frame_clk  in  1  VGA_VS; the frame tick is its rising edge
battle_l  in  1  high while stage_control is in battle; hits are ignored when low
player_hit  in  1  level: enemy projectile overlaps the player (hitbox contact)
npc_hit  in  1  level: player projectile overlaps the NPC (bullet_contact)
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
Player_HP  out  8  current player HP
NPC_HP  out  8  current NPC HP
Player_Dead  out  1  registered; high while player is in DEAD
NPC_Dead  out  1  registered; high while NPC is in DEAD
is_player_bar  out  1  combinational: pixel lies in the player bar
is_npc_bar  out  1  combinational: pixel lies in the NPC bar

Behaviour:
- Frame tick: register frame_clk_delayed <= frame_clk each Clk. tick = frame_clk & ~frame_clk_delayed, a one-Clk pulse.
- Reset (overrides everything, any state):
  - both HP = MAX_HP
  - both FSMs = ALIVE
  - cooldown counters = 0, pending flags = 0
  - Dead outputs = 0, frame_clk_delayed = 0
- Hit capture, per character:
  - pending is sticky. It is set on any Clk where hit && battle_l, and is cleared on every tick.
  - A hit level that spans many clocks within a frame counts as one pending hit.
  - When battle_l is low, pending is cleared every Clk.
- Per-character FSM, advances only on tick (all registers hold between ticks):
  - ALIVE:
    - If pending (or hit && battle_l in the tick cycle itself): new_hp = (HP > DAMAGE) ? HP - DAMAGE : 0. Saturating; never wraps.
    - If new_hp == 0: go to DEAD.
    - Otherwise: go to COOLDOWN with counter = COOLDOWN_FRAMES.
    - If no hit: stay in ALIVE.
  - COOLDOWN:
    - Hits are discarded.
    - counter decrements each tick. On the tick where counter == 1, go to ALIVE.
    - This gives exactly COOLDOWN_FRAMES immune ticks.
  - DEAD: HP = 0, Dead = 1. Held until Reset; no exit otherwise.
- Latency: HP and Dead update in the Clk cycle after the tick edge is detected, i.e. registered on the tick cycle.
- Both characters are independent. If both are killed on the same tick, both Dead rise on the same cycle; arbitration belongs to stage_control.
- A battle_l fall mid-cooldown freezes nothing: the cooldown keeps counting on ticks, but no new hits are accepted.
- Bars, pure combinational, with 8-bit HP zero-extended to 10 bits:
  - Rows: DrawY >= BAR_Y and DrawY < BAR_Y + BAR_H.
  - is_player_bar: rows match and P_BAR_X <= DrawX < P_BAR_X + Player_HP.
  - is_npc_bar: rows match and N_BAR_X - NPC_HP < DrawX <= N_BAR_X.
  - HP = 0 gives an empty bar: no pixels asserted.
- No output glitches on Reset release. First tick after release behaves as ALIVE with full HP.

Test Plan:
- Reset, battle_l=1, pulse npc_hit for 3 Clk mid-frame, then tick -> NPC_HP 100->90; state COOLDOWN; Player_HP stays 100; NPC_Dead=0.
- After that hit, hold npc_hit=1 continuously -> NPC_HP stays 90 for 30 ticks, then drops to 80 on the first tick after return to ALIVE.
- Hit on each accepted opportunity with MAX_HP=100, DAMAGE=10 -> after the 10th accepted hit NPC_HP=0 and NPC_Dead=1 one cycle after the tick; further hits leave HP at 0.
- MAX_HP=15, DAMAGE=10, two accepted hits -> HP 15->5->0 (saturation, no wrap to 251); Dead asserted.
- battle_l=0 with player_hit=1 for 5 frames -> Player_HP stays 100; raise battle_l -> the next tick applies damage (HP 90).
- Both hits lethal on the same tick -> Player_Dead and NPC_Dead rise on the same cycle. Assert Reset mid-cooldown -> next cycle both HP=100, both Dead=0.
- Bars with Player_HP=90, NPC_HP=50: DrawY=20, DrawX=109 -> is_player_bar=1; DrawX=110 -> 0. DrawX=570 -> is_npc_bar=1; DrawX=569 -> 0. DrawY=28 -> both 0.
